// File: rtl/ultrasonic_trigger.sv
// HC-SR04-style ranging sequencer: fires a fixed-width trig pulse, times the echo
// response, and enforces a minimum repeat period between trigger rises.
module ultrasonic_trigger #(
    parameter int unsigned TRIG_CYCLES      = 480,
    parameter int unsigned PERIOD_CYCLES    = 2880000,
    parameter int unsigned ECHO_WAIT_CYCLES = 1440000,
    parameter int unsigned ECHO_MAX_CYCLES  = 1824000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic start,
    input  logic Echo_sign,
    output logic trig,
    output logic busy,
    output logic done,
    output logic timeout
);

    localparam int unsigned PH_W  = 21;
    localparam int unsigned PER_W = 22;

    localparam logic [PH_W-1:0]  TRIG_LAST = PH_W'(TRIG_CYCLES - 1);
    localparam logic [PH_W-1:0]  WAIT_LAST = PH_W'(ECHO_WAIT_CYCLES - 1);
    localparam logic [PH_W-1:0]  ECHO_LAST = PH_W'(ECHO_MAX_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_WAIT_FALL,
        S_HOLDOFF
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic              echo_meta_q, echo_sync_q;
    logic              trig_q, trig_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic              echo_rise;
    logic              echo_fall;

    // Edges are taken between the two synchronizer stages.
    assign echo_rise = echo_meta_q & ~echo_sync_q;
    assign echo_fall = ~echo_meta_q & echo_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_meta_q <= 1'b0;
            echo_sync_q <= 1'b0;
        end else begin
            echo_meta_q <= Echo_sign;
            echo_sync_q <= echo_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            period_q  <= '0;
            trig_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            period_q  <= period_d;
            trig_q    <= trig_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + 21'd1;
        period_d  = (period_q == PER_LAST) ? period_q : period_q + 22'd1;
        done_d    = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                phase_d  = '0;
                period_d = '0;
                if (start || enable) begin
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                if (phase_q == TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                    phase_d = '0;
                end
            end
            S_WAIT_RISE: begin
                // An edge on the terminal-count cycle still counts as a rise.
                if (echo_rise) begin
                    state_d = S_WAIT_FALL;
                    phase_d = '0;
                end else if (phase_q == WAIT_LAST) begin
                    state_d   = S_HOLDOFF;
                    timeout_d = 1'b1;
                end
            end
            S_WAIT_FALL: begin
                if (echo_fall) begin
                    state_d = S_HOLDOFF;
                    done_d  = 1'b1;
                end else if (phase_q == ECHO_LAST) begin
                    state_d   = S_HOLDOFF;
                    timeout_d = 1'b1;
                end
            end
            S_HOLDOFF: begin
                phase_d = phase_q;
                if (period_q == PER_LAST) begin
                    if (enable) begin
                        state_d  = S_TRIG;
                        phase_d  = '0;
                        period_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        trig_d = (state_d == S_TRIG);
    end

    assign trig    = trig_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_ultrasonic_trigger.sv
// Scenario bench: each scenario is a per-cycle stimulus table; a timeline model
// derives expected trig/busy/done/timeout waveforms from the measurement rules.
module tb_ultrasonic_trigger;

    localparam int T = 4;
    localparam int P = 100;
    localparam int W = 20;
    localparam int M = 30;
    localparam int N = 512;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic start = 1'b0;
    logic Echo_sign = 1'b0;
    logic trig, busy, done, timeout;

    always #5 clk = ~clk;

    ultrasonic_trigger #(
        .TRIG_CYCLES      (T),
        .PERIOD_CYCLES    (P),
        .ECHO_WAIT_CYCLES (W),
        .ECHO_MAX_CYCLES  (M)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .start     (start),
        .Echo_sign (Echo_sign),
        .trig      (trig),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    int checks = 0;
    int failures = 0;

    bit start_v[N];
    bit enable_v[N];
    bit echo_v[N];
    bit rst_v[N];
    bit e_trig[N];
    bit e_busy[N];
    bit e_done[N];
    bit e_to[N];

    int obs_done_cnt, obs_to_cnt, obs_done_cyc, obs_to_cyc, obs_busy_fall;
    int trig_rises[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_scen();
        for (int k = 0; k < N; k++) begin
            start_v[k]  = 1'b0;
            enable_v[k] = 1'b0;
            echo_v[k]   = 1'b0;
            rst_v[k]    = 1'b0;
        end
    endtask

    task automatic echo_pulse(input int from, input int width);
        for (int k = from; k < from + width && k < N; k++) echo_v[k] = 1'b1;
    endtask

    // Synchronizer view: at cycle k the DUT sees echo as driven in k-1 and k-2.
    function automatic bit echo_at(input int k);
        if (k < 0 || k >= N) return 1'b0;
        return echo_v[k];
    endfunction

    function automatic bit rise_at(input int k);
        return echo_at(k - 1) && !echo_at(k - 2);
    endfunction

    function automatic bit fall_at(input int k);
        return !echo_at(k - 1) && echo_at(k - 2);
    endfunction

    task automatic mark_to(input int k);
        if (k >= 0 && k < N) e_to[k] = 1'b1;
    endtask

    task automatic mark_done(input int k);
        if (k >= 0 && k < N) e_done[k] = 1'b1;
    endtask

    // One measurement whose request was sampled at cycle c0.
    task automatic model_meas(input int c0);
        int rk;
        bit found;
        for (int k = c0 + 1; k <= c0 + P && k < N; k++) e_busy[k] = 1'b1;
        for (int k = c0 + 1; k <= c0 + T && k < N; k++) e_trig[k] = 1'b1;
        found = 1'b0;
        rk = 0;
        for (int k = c0 + T + 1; k < c0 + T + 1 + W; k++)
            if (!found && rise_at(k)) begin
                found = 1'b1;
                rk = k;
            end
        if (!found) begin
            mark_to(c0 + T + 1 + W);
        end else begin
            found = 1'b0;
            for (int j = rk + 1; j <= rk + M; j++)
                if (!found && fall_at(j)) begin
                    found = 1'b1;
                    mark_done(j + 1);
                end
            if (!found) mark_to(rk + M + 1);
        end
    endtask

    task automatic model_from(input int from);
        int c;
        c = from;
        while (c < N) begin
            if (!(start_v[c] || enable_v[c])) begin
                c++;
            end else begin
                model_meas(c);
                // Holdoff exit only looks at enable; otherwise idle resumes a cycle later.
                if (c + P < N && enable_v[c + P]) c = c + P;
                else c = c + P + 1;
            end
        end
    endtask

    task automatic build_model();
        int ra, re;
        for (int k = 0; k < N; k++) begin
            e_trig[k] = 1'b0;
            e_busy[k] = 1'b0;
            e_done[k] = 1'b0;
            e_to[k]   = 1'b0;
        end
        model_from(0);
        ra = -1;
        re = -1;
        for (int k = 0; k < N; k++)
            if (rst_v[k]) begin
                if (ra < 0) ra = k;
                re = k;
            end
        if (ra >= 0) begin
            for (int k = ra; k < N; k++) begin
                e_trig[k] = 1'b0;
                e_busy[k] = 1'b0;
                e_done[k] = 1'b0;
                e_to[k]   = 1'b0;
            end
            model_from(re + 1);
        end
    endtask

    task automatic run_scen(input string name, input int len);
        logic prev_trig, prev_busy;
        build_model();
        obs_done_cnt  = 0;
        obs_to_cnt    = 0;
        obs_done_cyc  = -1;
        obs_to_cyc    = -1;
        obs_busy_fall = -1;
        trig_rises.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b0;
        enable = 1'b0;
        Echo_sign = 1'b0;
        @(negedge clk);
        chk({name, ":rst_trig"}, 32'(trig), 32'd0);
        chk({name, ":rst_busy"}, 32'(busy), 32'd0);
        chk({name, ":rst_done"}, 32'(done), 32'd0);
        chk({name, ":rst_timeout"}, 32'(timeout), 32'd0);
        @(posedge clk); #1;
        prev_trig = 1'b0;
        prev_busy = 1'b0;
        for (int k = 0; k < len; k++) begin
            rst = rst_v[k];
            start = start_v[k];
            enable = enable_v[k];
            Echo_sign = echo_v[k];
            @(negedge clk);
            chk($sformatf("%s:trig@%0d", name, k), 32'(trig), 32'(e_trig[k]));
            chk($sformatf("%s:busy@%0d", name, k), 32'(busy), 32'(e_busy[k]));
            chk($sformatf("%s:done@%0d", name, k), 32'(done), 32'(e_done[k]));
            chk($sformatf("%s:timeout@%0d", name, k), 32'(timeout), 32'(e_to[k]));
            if (trig && !prev_trig) trig_rises.push_back(k);
            if (done) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) obs_done_cyc = k;
            end
            if (timeout) begin
                obs_to_cnt++;
                if (obs_to_cyc < 0) obs_to_cyc = k;
            end
            if (!busy && prev_busy && obs_busy_fall < 0) obs_busy_fall = k;
            prev_trig = trig;
            prev_busy = busy;
            @(posedge clk); #1;
        end
        $display("scenario %s cycles=%0d trig_pulses=%0d done=%0d timeout=%0d",
                 name, len, trig_rises.size(), obs_done_cnt, obs_to_cnt);
    endtask

    initial begin
        int s, d, wdt, use_en;

        clear_scen();
        start_v[0] = 1'b1;
        echo_pulse(10, 10);
        run_scen("basic", 130);
        chk("basic_done_cycle", obs_done_cyc, 32'd22);
        chk("basic_busy_low_cycle", obs_busy_fall, 32'd101);
        chk("basic_trig_pulses", trig_rises.size(), 32'd1);

        clear_scen();
        s = $urandom_range(0, 5);
        start_v[s] = 1'b1;
        run_scen("no_echo", 140);
        chk("no_echo_timeout_cycle", obs_to_cyc, s + T + 1 + W);
        chk("no_echo_done_count", obs_done_cnt, 32'd0);

        clear_scen();
        start_v[0] = 1'b1;
        echo_pulse(8, 120);
        run_scen("echo_stuck", 130);
        chk("echo_stuck_timeout_cycle", obs_to_cyc, 32'd40);
        chk("echo_stuck_done_count", obs_done_cnt, 32'd0);

        clear_scen();
        start_v[0] = 1'b1;
        echo_pulse(2, 40);
        run_scen("echo_in_trig", 130);
        chk("echo_in_trig_timeout_cycle", obs_to_cyc, 32'd25);

        clear_scen();
        for (int k = 0; k < 350; k++) enable_v[k] = 1'b1;
        for (int i = 0; i < 4; i++)
            echo_pulse(1 + P * i + T + $urandom_range(2, 15), $urandom_range(3, 25));
        run_scen("auto_repeat", 420);
        chk("auto_repeat_trig_pulses", trig_rises.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("auto_repeat_rise%0d", i), trig_rises[i], 1 + P * i);
        chk("auto_repeat_done_count", obs_done_cnt, 32'd4);

        clear_scen();
        start_v[0] = 1'b1;
        echo_pulse(10, 21);
        for (int k = 20; k < 23; k++) rst_v[k] = 1'b1;
        start_v[40] = 1'b1;
        echo_pulse(55, 6);
        run_scen("mid_reset", 160);
        chk("mid_reset_trig_pulses", trig_rises.size(), 32'd2);
        chk("mid_reset_second_rise", trig_rises[1], 32'd41);
        chk("mid_reset_done_count", obs_done_cnt, 32'd1);
        chk("mid_reset_timeout_count", obs_to_cnt, 32'd0);

        clear_scen();
        start_v[0] = 1'b1;
        echo_pulse(12, 7);
        start_v[15] = 1'b1;
        start_v[16] = 1'b1;
        start_v[50] = 1'b1;
        start_v[90] = 1'b1;
        run_scen("start_while_busy", 130);
        chk("start_while_busy_trig_pulses", trig_rises.size(), 32'd1);

        clear_scen();
        start_v[0] = 1'b1;
        echo_pulse(T + W - 1, 5);
        run_scen("rise_on_last", 130);
        chk("rise_on_last_timeout_count", obs_to_cnt, 32'd0);
        chk("rise_on_last_done_count", obs_done_cnt, 32'd1);

        clear_scen();
        start_v[0] = 1'b1;
        echo_pulse(T + W, 5);
        run_scen("rise_late", 130);
        chk("rise_late_timeout_cycle", obs_to_cyc, 32'd25);
        chk("rise_late_done_count", obs_done_cnt, 32'd0);

        clear_scen();
        start_v[0] = 1'b1;
        echo_pulse(10, M);
        run_scen("fall_on_last", 130);
        chk("fall_on_last_done_count", obs_done_cnt, 32'd1);
        chk("fall_on_last_timeout_count", obs_to_cnt, 32'd0);

        clear_scen();
        start_v[0] = 1'b1;
        echo_pulse(10, M + 1);
        run_scen("fall_late", 130);
        chk("fall_late_timeout_cycle", obs_to_cyc, 32'd42);
        chk("fall_late_done_count", obs_done_cnt, 32'd0);

        for (int it = 0; it < 6; it++) begin
            clear_scen();
            s = $urandom_range(0, 5);
            use_en = $urandom_range(0, 1);
            if (use_en != 0) begin
                for (int k = s; k <= s + 150; k++) enable_v[k] = 1'b1;
            end else begin
                start_v[s] = 1'b1;
            end
            d = s + T + $urandom_range(0, W + 3);
            wdt = $urandom_range(1, M + 3);
            echo_pulse(d, wdt);
            start_v[$urandom_range(s + 10, s + 90)] = 1'b1;
            run_scen($sformatf("random%0d", it), 330);
            chk($sformatf("random%0d_one_result_per_trig", it),
                obs_done_cnt + obs_to_cnt, trig_rises.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ultrasonic_trigger.md
ULTRASONIC_TRIGGER -- requirements
Module: ultrasonic_trigger

Interface
REQ-001 Parameters: TRIG_CYCLES, 480, trig high width in clk cycles (10 us at 48 MHz).
REQ-002 PERIOD_CYCLES, 2880000, minimum trig-rise to trig-rise spacing (60 ms).
REQ-003 ECHO_WAIT_CYCLES, 1440000, max cycles from trig fall to echo rise (30 ms).
REQ-004 ECHO_MAX_CYCLES, 1824000, max echo high width (38 ms).
REQ-005 clk  input  1  system clock, 48 MHz.
REQ-006 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-007 enable  input  1  auto-repeat mode; while high, measurements repeat every PERIOD_CYCLES.
REQ-008 start  input  1  single-shot request; sampled only in IDLE.
REQ-009 Echo_sign  input  1  sensor echo line, asynchronous to clk.
REQ-010 trig  output  1  sensor trigger pulse, registered.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle pulse: valid echo completed.
REQ-013 timeout  output  1  one-cycle pulse: echo missing or too long.

Function
REQ-014 Echo_sign SHALL pass a 2-flop synchronizer; rise/fall detection SHALL use the two synchronized flops only.
REQ-015 FSM states SHALL be IDLE, TRIG, WAIT_RISE, WAIT_FALL, HOLDOFF, driven by one shared 21-bit phase counter plus one 22-bit period counter.
REQ-016 IDLE -> TRIG on the cycle after (start | enable) is sampled high; phase and period counters cleared.
REQ-017 trig SHALL be high in exactly TRIG_CYCLES consecutive cycles, starting the cycle after the IDLE/HOLDOFF exit.
REQ-018 TRIG -> WAIT_RISE when phase counter = TRIG_CYCLES-1; phase counter cleared.
REQ-019 WAIT_RISE -> WAIT_FALL on synchronized rising edge; phase counter cleared.
REQ-020 WAIT_RISE -> HOLDOFF with timeout pulse when phase counter = ECHO_WAIT_CYCLES-1 and no rise that cycle.
REQ-021 WAIT_FALL -> HOLDOFF with done pulse on synchronized falling edge.
REQ-022 WAIT_FALL -> HOLDOFF with timeout pulse when phase counter = ECHO_MAX_CYCLES-1 and no fall that cycle.
REQ-023 Edge and terminal count in the same cycle: edge SHALL win (no timeout, normal transition).
REQ-024 Echo already high on entry to WAIT_RISE: no rise edge exists, SHALL end in timeout; echo rising during TRIG SHALL be ignored.
REQ-025 Period counter SHALL increment every non-IDLE cycle from trig rise, saturating at PERIOD_CYCLES-1.
REQ-026 HOLDOFF exit when period counter = PERIOD_CYCLES-1: -> TRIG if enable high, else -> IDLE.
REQ-027 HOLDOFF SHALL always be served in full, single-shot included; start while busy SHALL be ignored, not queued.
REQ-028 enable dropping mid-measurement SHALL NOT abort; cycle completes, then HOLDOFF -> IDLE.
REQ-029 done and timeout SHALL be mutually exclusive, at most one pulse per trigger.

Reset
REQ-030 While rst high: state IDLE, trig=0, busy=0, done=0, timeout=0, counters=0, synchronizer flops=0.
REQ-031 rst asserted mid-operation SHALL force trig low immediately (asynchronous) and discard the measurement; no done/timeout after release.
REQ-032 After rst release, first trigger SHALL require start or enable sampled in IDLE.

Verification (TRIG_CYCLES=4, PERIOD_CYCLES=100, ECHO_WAIT_CYCLES=20, ECHO_MAX_CYCLES=30)
REQ-033 start pulse at cycle 0, echo high cycles 10-19 -> trig high cycles 1-4, done one pulse ~cycle 22, busy low at cycle 101.
REQ-034 start, echo never rises -> timeout one pulse 20 cycles after trig falls, no done, busy low after period.
REQ-035 start, echo high from cycle 8 and held -> timeout 30 cycles after synchronized rise, no done.
REQ-036 enable held high 350 cycles, echo pulse per trigger -> trig rises at cycles 1, 101, 201, 301; four done pulses.
REQ-037 rst asserted during WAIT_FALL -> trig/busy 0 same cycle, no done/timeout; start after release -> normal trig.
REQ-038 start re-pulsed during WAIT_FALL and HOLDOFF -> ignored; exactly one trig pulse per period.
